// File: rtl/melody_event_encoder.sv
// OK-8 melody byte-stream encoder: two 6-bit note channels in, valid/ready byte stream out.
// Optional MELODY_ENC_BYTECOUNT_EN adds a saturating byte_count of transfers since recording started.
module melody_event_encoder #(
  parameter int TICK_CYCLES = 1200000,
  parameter int TICK_W      = 21
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       rec,
  input  logic [5:0] ch1_note,
  input  logic [5:0] ch2_note,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef MELODY_ENC_BYTECOUNT_EN
  output logic [15:0] byte_count,
`endif
  output logic       busy
);

  // state      | meaning
  // S_OFF      | not recording, prev notes follow inputs, timers held at 0
  // S_IDLE     | recording, waiting for a note change, saturation or rec drop
  // S_EMIT_DLY | presenting delay byte {10,dly}
  // S_EMIT_N1  | presenting channel 1 byte {00,prev1}
  // S_EMIT_N2  | presenting channel 2 byte {01,prev2}
  // S_EMIT_SAT | presenting 0xBF (delay count saturated)
  // S_EMIT_END | presenting end marker 0xC0
  typedef enum logic [2:0] {
    S_OFF, S_IDLE, S_EMIT_DLY, S_EMIT_N1, S_EMIT_N2, S_EMIT_SAT, S_EMIT_END
  } state_t;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  state_t            state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [5:0]        dly_q, dly_d;
  logic [5:0]        prev1_q, prev1_d;
  logic [5:0]        prev2_q, prev2_d;
  logic              chg1_q, chg1_d;
  logic              chg2_q, chg2_d;
  logic              end_q, end_d;
  logic              rec_q, rec_d;
  logic              xfer;
  logic              diff1, diff2;

  assign out_valid = (state_q != S_OFF) && (state_q != S_IDLE);
  assign busy      = out_valid;
  assign xfer      = out_valid && out_ready;
  assign diff1     = (ch1_note != prev1_q);
  assign diff2     = (ch2_note != prev2_q);

  always_comb begin
    out_byte = 8'h00;
    case (state_q)
      S_EMIT_DLY: out_byte = {2'b10, dly_q};
      S_EMIT_N1:  out_byte = {2'b00, prev1_q};
      S_EMIT_N2:  out_byte = {2'b01, prev2_q};
      S_EMIT_SAT: out_byte = 8'hBF;
      S_EMIT_END: out_byte = 8'hC0;
      default:    out_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    prev1_d = prev1_q;
    prev2_d = prev2_q;
    chg1_d  = chg1_q;
    chg2_d  = chg2_q;
    end_d   = end_q;
    rec_d   = rec;

    // Ticks accumulate in every recording state, including while bytes are stalled.
    if (state_q != S_OFF) begin
      if (presc_q == TICK_LAST) begin
        presc_d = '0;
        if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    case (state_q)
      S_OFF: begin
        prev1_d = ch1_note;
        prev2_d = ch2_note;
        presc_d = '0;
        cnt_d   = '0;
        if (rec && !rec_q) begin
          chg1_d  = 1'b1;
          chg2_d  = 1'b1;
          end_d   = 1'b0;
          state_d = S_EMIT_N1;
        end
      end
      S_IDLE: begin
        if (!rec) begin
          dly_d   = cnt_q;
          cnt_d   = '0;
          presc_d = '0;
          end_d   = 1'b1;
          state_d = (cnt_q != 6'd0) ? S_EMIT_DLY : S_EMIT_END;
        end else if (diff1 || diff2) begin
          prev1_d = ch1_note;
          prev2_d = ch2_note;
          chg1_d  = diff1;
          chg2_d  = diff2;
          dly_d   = cnt_q;
          cnt_d   = '0;
          presc_d = '0;
          end_d   = 1'b0;
          if (cnt_q != 6'd0) state_d = S_EMIT_DLY;
          else if (diff1)    state_d = S_EMIT_N1;
          else               state_d = S_EMIT_N2;
        end else if (cnt_q == 6'd63) begin
          cnt_d   = '0;
          presc_d = '0;
          state_d = S_EMIT_SAT;
        end
      end
      S_EMIT_DLY: if (xfer) begin
        if (end_q)       state_d = S_EMIT_END;
        else if (chg1_q) state_d = S_EMIT_N1;
        else             state_d = S_EMIT_N2;
      end
      S_EMIT_N1:  if (xfer) state_d = chg2_q ? S_EMIT_N2 : S_IDLE;
      S_EMIT_N2:  if (xfer) state_d = S_IDLE;
      S_EMIT_SAT: if (xfer) state_d = S_IDLE;
      S_EMIT_END: if (xfer) state_d = S_OFF;
      default:    state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_OFF;
      presc_q <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
      prev1_q <= '0;
      prev2_q <= '0;
      chg1_q  <= 1'b0;
      chg2_q  <= 1'b0;
      end_q   <= 1'b0;
      rec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      prev1_q <= prev1_d;
      prev2_q <= prev2_d;
      chg1_q  <= chg1_d;
      chg2_q  <= chg2_d;
      end_q   <= end_d;
      rec_q   <= rec_d;
    end
  end

`ifdef MELODY_ENC_BYTECOUNT_EN
  logic [15:0] bc_q, bc_d;

  always_comb begin
    bc_d = bc_q;
    if (state_q == S_OFF && rec && !rec_q) bc_d = '0;
    else if (xfer && bc_q != 16'hFFFF)     bc_d = bc_q + 16'd1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) bc_q <= '0;
    else          bc_q <= bc_d;
  end

  assign byte_count = bc_q;
`endif

endmodule

// File: doc/melody_event_encoder.md
Name: melody_event_encoder

Overview:
- Records live two-channel note activity as the OK-8 melody byte stream that the OK-8 melody player consumes.
- Watches two 6-bit note inputs and emits bytes on a valid/ready stream:
  - note-change bytes (channel 1 = 00nnnnnn, channel 2 = 01nnnnnn);
  - delay bytes (10dddddd, d = elapsed 100 ms ticks);
  - an end marker (0xC0).
- Sits between a keyboard/front-end and a byte memory writer. It is the encoder for the player's decoder.

Parameters:
- TICK_CYCLES, 1200000, clk cycles per delay tick (100 ms at 12 MHz); legal range ≥ 2.
- TICK_W, 21, width of the prescaler counter; must hold TICK_CYCLES-1.

Ports:
- clk  in  1  system clock (12 MHz nominal)
- n_reset  in  1  asynchronous active-low reset
- rec  in  1  record enable, level sensitive
- ch1_note  in  6  channel 1 note index, 0 = silence
- ch2_note  in  6  channel 2 note index, 0 = silence
- out_byte  out  8  encoded melody byte
- out_valid  out  1  out_byte is valid
- out_ready  in  1  sink accepts the byte
- busy  out  1  FSM not in IDLE/OFF

Behaviour:
- Reset (async, n_reset=0):
  - out_byte=0, out_valid=0, busy=0.
  - Prescaler=0, delay count=0, prev1=prev2=0, state=OFF.
  - Takes effect mid-transfer: any pending byte is dropped.
- Handshake:
  - A transfer occurs on a clk edge with out_valid=1 and out_ready=1.
  - While out_valid=1, out_byte is stable. out_valid never drops without a transfer, except on reset.
  - Back-to-back: the next byte may be valid the cycle after a transfer.
- Tick prescaler:
  - Runs only while state≠OFF and wraps at TICK_CYCLES-1.
  - Each wrap increments the delay count, which saturates at 63 and never wraps.
- States: OFF, IDLE, EMIT_DLY, EMIT_N1, EMIT_N2, EMIT_SAT, EMIT_END.
- OFF:
  - prev1/prev2 track the inputs every cycle; prescaler and count are held at 0.
  - On rec rising: snapshot both notes, set chg1=chg2=1 (both initial notes always emitted), go to EMIT_N1.
- IDLE, note change (ch1_note≠prev1 or ch2_note≠prev2):
  - Snapshot both notes into prev1/prev2.
  - chg1 = (ch1_note≠prev1), chg2 likewise.
  - Latch the delay count into dly, then clear count and prescaler in the same cycle.
  - Go to EMIT_DLY if dly>0, else to the first flagged note state.
- IDLE, count==63 with no change: go to EMIT_SAT, clearing count and prescaler.
- IDLE, rec=0: latch dly as above, go to EMIT_DLY (if dly>0) then EMIT_END.
- Priority in IDLE: rec=0 over note change over saturation.
- Emit states:
  - EMIT_DLY drives {2'b10,dly}.
  - EMIT_N1 drives {2'b00,prev1} and is skipped if chg1=0.
  - EMIT_N2 drives {2'b01,prev2} and is skipped if chg2=0.
  - EMIT_SAT drives 0xBF.
  - EMIT_END drives 0xC0, then goes to OFF.
  - Each state advances only on transfer. After the last note or saturation byte, return to IDLE.
- During emission:
  - Ticks keep accumulating into count.
  - Input changes are not sampled. Changes are detected afterwards against the snapshot, so intermediate values that revert are lost by design.
- rec falling mid-sequence: the current sequence completes; the IDLE rule then emits the final delay and end marker.
- rec rising during emission: ignored until OFF is reached.
- Latency: first byte is valid the cycle after the detecting edge (registered output).

Optional Feature:
- Macro: MELODY_ENC_BYTECOUNT_EN.
- When defined:
  - Adds output byte_count [15:0]: number of transfers since the last rec rising edge (cleared on that edge).
  - Saturates at 0xFFFF; reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (TICK_CYCLES=10):
- Reset with rec=0, then raise rec with ch1=5, ch2=0 → stream 0x05, 0x40, then idle; busy returns to 0.
- Hold 30 cycles, change ch1 to 8 → 0x83, 0x08 (no ch2 byte).
- Change ch1 and ch2 in the same cycle, before any tick → 0x0A-style pair with no delay byte, e.g. ch1=10, ch2=3 gives 0x0A, 0x43.
- Hold for 640 cycles with no change → 0xBF once the count reaches 63, then later delay counting restarts from 0.
- out_ready low for 20 cycles during a delay byte → out_valid held, byte stable, no loss; changing ch2 meanwhile gives a later pair with the correct new delay.
- rec falls 25 cycles after the last byte → 0x82, 0xC0, state OFF. Assert n_reset mid-byte → out_valid=0 immediately; a later rec rising restarts cleanly with initial notes.
